// File: rtl/onehot_seq_ctrl_if.sv
// Control and status bundle between the switch inputs and the
// one-hot LED sequencer.
interface onehot_seq_ctrl_if;
    logic       en;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       step_req;
    logic       load;
    logic [2:0] load_idx;
    logic [2:0] idx_o;
    logic [7:0] onehot_o;
    logic       adv_o;
    logic       wrap_o;
    logic       dir_o;

    modport master (
        output en, mode, speed, step_req, load, load_idx,
        input  idx_o, onehot_o, adv_o, wrap_o, dir_o
    );

    modport slave (
        input  en, mode, speed, step_req, load, load_idx,
        output idx_o, onehot_o, adv_o, wrap_o, dir_o
    );
endinterface

// File: rtl/onehot_seq_ctrl.sv
// Timed 3-bit index sequencer for the one-hot LED decoder:
// prescaled walk up/down/bounce, manual step and index load.
module onehot_seq_ctrl #(
    parameter int BASE_SHIFT = 2,
    parameter int DIV_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    onehot_seq_ctrl_if.slave bus
);
    typedef enum logic {UP = 1'b0, DN = 1'b1} dir_t;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;
    logic [2:0]       idx;
    logic [2:0]       idx_d;
    logic [7:0]       onehot;
    dir_t             dir;
    dir_t             dir_d;
    logic             adv;
    logic             adv_d;
    logic             wrap;
    logic             wrap_d;
    logic             tick;

    // Shift overflow at the widest setting wraps to all-ones, still correct.
    always_comb begin
        lim = (DIV_W'(1) << (BASE_SHIFT + int'(bus.speed)))
            - DIV_W'(1);
    end

    assign tick = bus.en && (cnt >= lim);

    always_comb begin
        idx_d  = idx;
        dir_d  = dir;
        adv_d  = 1'b0;
        wrap_d = 1'b0;
        unique case (bus.mode)
            2'b00: begin
                if (bus.en && bus.step_req) begin
                    idx_d  = idx + 3'd1;
                    adv_d  = 1'b1;
                    wrap_d = (idx == 3'd7);
                end
            end
            2'b01: begin
                if (tick) begin
                    idx_d  = idx + 3'd1;
                    dir_d  = UP;
                    adv_d  = 1'b1;
                    wrap_d = (idx == 3'd7);
                end
            end
            2'b10: begin
                if (tick) begin
                    idx_d  = idx - 3'd1;
                    dir_d  = DN;
                    adv_d  = 1'b1;
                    wrap_d = (idx == 3'd0);
                end
            end
            2'b11: begin
                if (tick) begin
                    adv_d = 1'b1;
                    if (dir == UP) begin
                        if (idx == 3'd7) begin
                            idx_d  = 3'd6;
                            dir_d  = DN;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx + 3'd1;
                        end
                    end else begin
                        if (idx == 3'd0) begin
                            idx_d  = 3'd1;
                            dir_d  = UP;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx - 3'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 3'd0;
            onehot <= 8'h01;
            dir    <= UP;
            adv    <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            adv  <= 1'b0;
            wrap <= 1'b0;
            if (bus.load) begin
                // A coincident tick or step is dropped; dir is kept.
                idx    <= bus.load_idx;
                onehot <= 8'h01 << bus.load_idx;
                cnt    <= '0;
            end else begin
                if (tick) begin
                    cnt <= '0;
                end else if (bus.en) begin
                    cnt <= cnt + DIV_W'(1);
                end
                idx    <= idx_d;
                onehot <= 8'h01 << idx_d;
                dir    <= dir_d;
                adv    <= adv_d;
                wrap   <= wrap_d;
            end
        end
    end

    assign bus.idx_o    = idx;
    assign bus.onehot_o = onehot;
    assign bus.adv_o    = adv;
    assign bus.wrap_o   = wrap;
    assign bus.dir_o    = (dir == DN);
endmodule

// File: tb/tb_onehot_seq_ctrl.sv
// Bench for onehot_seq_ctrl: directed phases plus random traffic,
// compared every cycle against a behavioural model.
module tb_onehot_seq_ctrl;
    localparam int BS = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    int m_idx  = 0;
    int m_dir  = 0;
    int m_cnt  = 0;
    int m_adv  = 0;
    int m_wrap = 0;

    onehot_seq_ctrl_if bus ();

    onehot_seq_ctrl #(.BASE_SHIFT(BS), .DIV_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t got %0h want %0h",
                      nm, $time, act, exp);
    endtask

    // Reference behaviour from the sequencer rules, one clock edge.
    task automatic model_step();
        int per;
        int tk;
        int na;
        int nw;
        na = 0;
        nw = 0;
        if (!rst_n) begin
            m_idx = 0; m_dir = 0; m_cnt = 0;
        end else begin
            per = 1 << (BS + int'(bus.speed));
            tk  = (bus.en && m_cnt >= per - 1) ? 1 : 0;
            if (bus.load) begin
                m_idx = int'(bus.load_idx);
                m_cnt = 0;
            end else begin
                if (bus.en) m_cnt = tk ? 0 : m_cnt + 1;
                case (bus.mode)
                    2'd0: if (bus.en && bus.step_req) begin
                        na = 1; nw = (m_idx == 7);
                        m_idx = (m_idx + 1) % 8;
                    end
                    2'd1: if (tk) begin
                        na = 1; nw = (m_idx == 7); m_dir = 0;
                        m_idx = (m_idx + 1) % 8;
                    end
                    2'd2: if (tk) begin
                        na = 1; nw = (m_idx == 0); m_dir = 1;
                        m_idx = (m_idx + 7) % 8;
                    end
                    default: if (tk) begin
                        na = 1;
                        if (m_dir == 0 && m_idx == 7) begin
                            m_dir = 1; nw = 1;
                        end else if (m_dir == 1 && m_idx == 0) begin
                            m_dir = 0; nw = 1;
                        end
                        m_idx = m_idx + (m_dir == 0 ? 1 : -1);
                    end
                endcase
            end
        end
        m_adv  = na;
        m_wrap = nw;
    endtask

    task automatic compare();
        chk("idx",    32'(bus.idx_o),    32'(m_idx));
        chk("onehot", 32'(bus.onehot_o), 32'(1 << m_idx));
        chk("dir",    32'(bus.dir_o),    32'(m_dir));
        chk("adv",    32'(bus.adv_o),    32'(m_adv));
        chk("wrap",   32'(bus.wrap_o),   32'(m_wrap));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_in(input logic e, input logic [1:0] m,
                          input logic [2:0] s);
        bus.en = e; bus.mode = m; bus.speed = s;
        bus.step_req = 1'b0; bus.load = 1'b0; bus.load_idx = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 2'd1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            bus.en       = 1'($urandom);
            bus.mode     = 2'($urandom);
            bus.speed    = 3'($urandom);
            bus.step_req = 1'($urandom);
            bus.load     = 1'($urandom);
            bus.load_idx = 3'($urandom);
            cyc();
        end
        chk("lit_rst_idx", 32'(bus.idx_o), 32'd0);
        chk("lit_rst_oh",  32'(bus.onehot_o), 32'h01);

        // Walk up at speed 0
        rst_n = 1'b1;
        set_in(1'b1, 2'd1, 3'd0);
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (i == 4)  chk("lit_walk_first", 32'(bus.idx_o), 32'd1);
            if (i == 28) chk("lit_walk_7", 32'(bus.idx_o), 32'd7);
            if (i == 32) begin
                chk("lit_walk_wrapidx", 32'(bus.idx_o), 32'd0);
                chk("lit_walk_wrap", 32'(bus.wrap_o), 32'd1);
            end
            if (i == 33) chk("lit_walk_wrapoff", 32'(bus.wrap_o), 32'd0);
        end

        // Bounce from reset
        set_in(1'b1, 2'd3, 3'd0);
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (i == 28) chk("lit_bnc_top", 32'(bus.idx_o), 32'd7);
            if (i == 32) begin
                chk("lit_bnc_turn", 32'(bus.idx_o), 32'd6);
                chk("lit_bnc_dir1", 32'(bus.dir_o), 32'd1);
                chk("lit_bnc_wrap", 32'(bus.wrap_o), 32'd1);
            end
            if (i == 56) chk("lit_bnc_bot", 32'(bus.idx_o), 32'd0);
            if (i == 60) begin
                chk("lit_bnc_up", 32'(bus.idx_o), 32'd1);
                chk("lit_bnc_dir0", 32'(bus.dir_o), 32'd0);
            end
        end

        // Load coincident with a tick
        set_in(1'b1, 2'd1, 3'd0);
        do_reset();
        idle(3);
        bus.load = 1'b1;
        bus.load_idx = 3'd5;
        cyc();
        chk("lit_load_idx", 32'(bus.idx_o), 32'd5);
        chk("lit_load_adv", 32'(bus.adv_o), 32'd0);
        bus.load = 1'b0;
        idle(3);
        chk("lit_load_hold", 32'(bus.idx_o), 32'd5);
        cyc();
        chk("lit_load_next", 32'(bus.idx_o), 32'd6);

        // Freeze mid-count
        idle(2);
        bus.en = 1'b0;
        idle(10);
        chk("lit_frz_idx", 32'(bus.idx_o), 32'd6);
        bus.en = 1'b1;
        cyc();
        chk("lit_frz_cnt", 32'(bus.idx_o), 32'd6);
        cyc();
        chk("lit_frz_adv", 32'(bus.idx_o), 32'd7);

        // Speed decrease mid-count
        set_in(1'b1, 2'd1, 3'd7);
        do_reset();
        idle(20);
        bus.speed = 3'd0;
        cyc();
        chk("lit_spd_idx", 32'(bus.idx_o), 32'd1);
        chk("lit_spd_adv", 32'(bus.adv_o), 32'd1);

        // Manual stepping from 6
        set_in(1'b1, 2'd0, 3'd0);
        bus.load = 1'b1;
        bus.load_idx = 3'd6;
        cyc();
        bus.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.step_req = 1'b1;
            cyc();
            bus.step_req = 1'b0;
            if (k == 0) chk("lit_man_7", 32'(bus.idx_o), 32'd7);
            if (k == 1) chk("lit_man_wrap", 32'(bus.wrap_o), 32'd1);
            idle(5);
        end
        chk("lit_man_1", 32'(bus.idx_o), 32'd1);
        do_reset();
        chk("lit_man_rst", 32'(bus.onehot_o), 32'h01);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom % 64) != 0;
            bus.en       = ($urandom % 8) != 0;
            bus.mode     = 2'($urandom);
            bus.speed    = 3'($urandom_range(0, 2));
            bus.step_req = 1'($urandom);
            bus.load     = ($urandom % 16) == 0;
            bus.load_idx = 3'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
